// File: rtl/down_counter_if.sv
// down_counter_if
//   Groups the control and status signals of the down_counter timer so the
//   block can be connected with a single port.
//
//   Signals (WIDTH-bit where noted):
//     en        count enable, decrement permitted when high
//     load      synchronous load strobe
//     load_val  value captured on load (WIDTH)
//     reload    auto-reload mode select, sampled at the expiry edge
//     count     current counter value, registered (WIDTH)
//     busy      high while the counter is running, registered
//     tc        terminal-count pulse, registered, one cycle wide
//     zero      combinational (count == 0)
//     state_dbg current FSM state for observation (0 = IDLE, 1 = RUN)
//
//   Handshake: there is no backpressure. load is a strobe that is taken on
//   every rising edge where it is high (unless reset is active); en, reload
//   and load_val are plain level inputs sampled on the same edge.
//
//   Modports: master drives the controls (testbench or host logic),
//   slave is the counter itself.
`timescale 1ns/1ps

interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             zero;
    logic             state_dbg;

    modport master (
        output en, load, load_val, reload,
        input  count, busy, tc, zero, state_dbg
    );

    modport slave (
        input  en, load, load_val, reload,
        output count, busy, tc, zero, state_dbg
    );
endinterface

// File: rtl/down_counter.sv
// down_counter
//   Loadable WIDTH-bit down-counter / interval timer. A load starts a count
//   from load_val; every enabled cycle in RUN decrements it. The edge that
//   takes the count from 1 to its expiry value raises tc for one cycle and
//   either stops the counter at 0 (one-shot) or reloads the last loaded
//   value (periodic tick generator, reload=1).
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset (rst=0 resets immediately)
//     bus  down_counter_if.slave: en, load, load_val, reload in;
//          count, busy, tc, zero, state_dbg out
//
//   Edge priority: reset > load > count.
`timescale 1ns/1ps

module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    down_counter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // A load overrides any expiry on the same edge, so tc stays low.
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = (bus.load_val != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                // Expiry edge: tc lines up with the cycle that first shows
                // the post-expiry count (0 or the reloaded value).
                tc_d = 1'b1;
                if (bus.reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end else begin
                // RUN with count 0 is unreachable; fall back to IDLE
                // without a pulse rather than wrapping to all-ones.
                state_d = IDLE;
            end
        end
    end

    assign bus.count     = count_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.tc        = tc_q;
    assign bus.zero      = (count_q == ZERO);
    assign bus.state_dbg = state_q;

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable 8-bit down-counter/timer.
- Counterpart to the team's up-counter: the up-counter measures elapsed cycles; this block counts a programmed interval down to zero.
- Flags expiry with a single-cycle terminal-count pulse.
- Optional auto-reload makes it a periodic tick generator.
- Sits beside the up-counter in the Circuitos timing blocks; the team's timescale convention is 1ns/1ps.

Parameters:
- WIDTH, 8, counter and load-value width in bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- en  input  1  count enable; decrement permitted when high.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured on load.
- reload  input  1  auto-reload mode select, sampled at the expiry edge.
- count  output  WIDTH  current counter value, registered.
- busy  output  1  high while in RUN state, registered.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.
- zero  output  1  combinational (count == 0).

Behaviour:
- Reset:
  - rst=0 takes effect immediately, with no clock edge needed.
  - count=0, reload register=0, state=IDLE, busy=0, tc=0, zero=1.
  - Reset asserted mid-count aborts the count; no tc is generated.
  - Release is synchronous to the next rising edge; the first edge with rst=1 acts normally.
- Internal state: two-state FSM (IDLE, RUN) and a WIDTH-bit reload register.
- Priority on every edge: reset > load > count.
- Load (load=1, any state):
  - count <= load_val; reload register <= load_val; tc <= 0.
  - load_val != 0: state <= RUN, busy <= 1.
  - load_val == 0: state <= IDLE, busy <= 0; tc is not generated.
  - en is ignored on a load edge.
- RUN, load=0, en=1, count > 1: count <= count-1; tc <= 0.
- RUN, load=0, en=1, count == 1 (expiry edge):
  - tc <= 1 for exactly one cycle, coincident with the cycle count first shows the expiry value.
  - reload=1: count <= reload register, stay RUN, busy stays 1.
  - reload=0: count <= 0, state <= IDLE, busy <= 0.
- RUN, en=0: count holds, busy holds 1, tc <= 0. A pause is unlimited in length; resuming continues from the held value.
- IDLE, load=0: count holds, en has no effect, tc <= 0.
  - Counter saturates at 0 and never wraps to all-ones.
- Timing:
  - Load value N >= 1 with en held high from the edge after load: tc is high during the N-th cycle after the load edge.
  - In reload mode, tc repeats with period N cycles.
- Simultaneous load and expiry on the same edge: load wins, tc stays 0, new value is loaded.
- tc never asserts for two consecutive cycles.
  - Exception: reload with a reload-register value of 1 gives tc every cycle; this is legal (period 1).
- Arithmetic: unsigned WIDTH-bit. load_val of all-ones (255) is legal and takes 255 enabled cycles.

Test Plan:
- Reset mid-count: load 10, en=1; after 3 edges drive rst=0 between clock edges -> count=0, busy=0, zero=1 immediately, without waiting for a clock edge; no tc pulse at any point.
- One-shot: load 5 with reload=0, en=1 -> count goes 5,4,3,2,1,0; tc=1 only in the cycle count=0; busy falls with it; count stays 0 for 20 further cycles with no wrap.
- Pause: load 6, en=1 for 2 edges (count=4), en=0 for 7 cycles -> count stays 4 and busy=1; en=1 again -> tc exactly 4 edges later.
- Auto-reload: load 3 with reload=1, en=1 for 12 cycles -> count cycles 3,2,1,3,2,1,...; tc pulses every 3 cycles, 4 pulses total; busy stays 1.
- Boundary loads:
  - load 0 -> busy=0, zero=1, no tc.
  - load 255 -> tc after exactly 255 enabled edges.
  - load 9 asserted on the expiry edge of a running count -> count=9, tc=0, busy=1.
